// File: rtl/sid_spi_master.sv
// -----------------------------------------------------------------------------
// sid_spi_master
//
// SPI transmitter for SID register writes (initiator end of the spi_slave
// link). Each accepted request is serialised as one 16-bit frame
// {1'b1 (write), 2'b00, addr[4:0], data[7:0]}, MSB first, SPI mode 0.
//
// Frame timing, in sclk half-periods of CLK_DIV clk cycles:
//   1 setup + 31 clocking (16 high, 15 low) + 2 hold = 34 with ss low,
//   followed by GAP_CYCLES clk cycles with ss high before the next frame.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset; aborts any frame in flight
//   req_valid  in   write request valid
//   req_ready  out  request accepted on the edge where req_valid && req_ready
//   req_addr   in   [4:0] SID register address
//   req_data   in   [7:0] register data
//   ss         out  slave select, active low
//   sclk       out  SPI clock, idles low
//   mosi       out  serial data, changes only on sclk falling edges
//   busy       out  high from request accept until the frame's gap ends
//   done       out  one-cycle pulse on the cycle ss returns high
//
// Configuration macro
//   SID_SPI_FIFO_EN  undefined: requests are taken straight into the shift
//                    register, req_ready is high only when a frame can start.
//                    defined:   FIFO_DEPTH-entry request FIFO ahead of the
//                    FSM, req_ready = !full.
// -----------------------------------------------------------------------------
module sid_spi_master #(
    parameter int CLK_DIV    = 2,   // clk cycles per sclk half-period, >= 1
    parameter int GAP_CYCLES = 2    // clk cycles ss stays high between frames, >= 1
`ifdef SID_SPI_FIFO_EN
    ,
    parameter int FIFO_DEPTH = 4    // power of 2, >= 2
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_data,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // The extra bit lets the half-period counter also time the two-half-period
    // hold without a separate counter.
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_LOAD = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    // Registered state and outputs
    state_t            r_state;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [4:0]        r_bit_cnt;    // sclk rises still to come, 16 down to 0
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [14:0]       r_shift;      // frame bits not yet on mosi, next at [14]
    logic              r_ss;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_done;

    // Next-state values
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  w_div_cnt_nxt;
    logic [4:0]        w_bit_cnt_nxt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic [14:0]       w_shift_nxt;
    logic              w_ss_nxt;
    logic              w_sclk_nxt;
    logic              w_mosi_nxt;
    logic              w_done_nxt;

    // Frame source and start control
    logic              w_can_start;  // IDLE, or the last GAP cycle
    logic              w_src_valid;
    logic [12:0]       w_src_word;   // {addr, data}
    logic              w_start;

    assign w_can_start = (r_state == ST_IDLE) ||
                         ((r_state == ST_GAP) && (r_gap_cnt == '0));
    assign w_start     = w_can_start && w_src_valid;

`ifdef SID_SPI_FIFO_EN
    // -------------------------------------------------------------------------
    // Request FIFO
    // -------------------------------------------------------------------------
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [12:0]   r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_push;
    logic          w_pop;

    assign w_fifo_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign req_ready    = !w_fifo_full;
    assign w_push       = req_valid && !w_fifo_full;
    assign w_pop        = w_start;
    assign w_src_valid  = !w_fifo_empty;
    assign w_src_word   = r_fifo_mem[r_rd_ptr];
    assign busy         = (r_state != ST_IDLE) || !w_fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read after being written,
    // and leaving it reset-free lets it map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= {req_addr, req_data};
    end
`else
    // Without a FIFO the request goes straight into the shift register, so
    // the accept edge is the frame-start edge.
    assign req_ready   = w_can_start;
    assign w_src_valid = req_valid;
    assign w_src_word  = {req_addr, req_data};
    assign busy        = (r_state != ST_IDLE);
`endif

    // -------------------------------------------------------------------------
    // FSM next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_shift_nxt   = r_shift;
        w_ss_nxt      = r_ss;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Frame start is handled below, shared with the GAP exit.
            end

            ST_SETUP: begin
                if (r_div_cnt == '0) begin
                    w_sclk_nxt    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt - 5'd1;
                    w_div_cnt_nxt = HALF_LOAD;
                    w_state_nxt   = ST_SHIFT;
                end else begin
                    w_div_cnt_nxt = r_div_cnt - 1'b1;
                end
            end

            ST_SHIFT: begin
                if (r_div_cnt == '0) begin
                    w_div_cnt_nxt = HALF_LOAD;
                    if (r_sclk) begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == '0) begin
                            // Final falling edge: bit0 stays on mosi.
                            w_div_cnt_nxt = HOLD_LOAD;
                            w_state_nxt   = ST_HOLD;
                        end else begin
                            w_mosi_nxt  = r_shift[14];
                            w_shift_nxt = {r_shift[13:0], 1'b0};
                        end
                    end else begin
                        w_sclk_nxt    = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt - 5'd1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt - 1'b1;
                end
            end

            ST_HOLD: begin
                if (r_div_cnt == '0) begin
                    w_ss_nxt      = 1'b1;
                    w_mosi_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = ST_GAP;
                end else begin
                    w_div_cnt_nxt = r_div_cnt - 1'b1;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Frame start from IDLE or straight out of the last GAP cycle, so
        // back-to-back frames see no extra IDLE cycle. Bits 15:13 of the
        // frame are the constant 3'b100: bit15 goes straight onto mosi.
        if (w_start) begin
            w_ss_nxt      = 1'b0;
            w_mosi_nxt    = 1'b1;
            w_shift_nxt   = {2'b00, w_src_word};
            w_div_cnt_nxt = HALF_LOAD;
            w_bit_cnt_nxt = 5'd16;
            w_state_nxt   = ST_SETUP;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_ss      <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ss      <= w_ss_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign ss   = r_ss;
    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign done = r_done;

endmodule
